// File: rtl/data_mem_pkg.sv
// Shared encodings, FSM state type and store-data alignment helper for the data RAM access unit.
package data_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam int DEFAULT_PULSE_CYCLES = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RESP
  } state_t;

  // The RAM expects store data right-aligned with unused upper lanes cleared.
  function automatic logic [31:0] format_store(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SIZE_BYTE: format_store = {24'b0, wdata[7:0]};
      SIZE_HALF: format_store = {16'b0, wdata[15:0]};
      default:   format_store = wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Combinational zero/sign extension of RAM read data; byte lives in [7:0], half in [15:0].
module mem_load_extend
  import data_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] dataout,
  output logic [31:0] rdata
);

  logic fill_byte;
  logic fill_half;

  assign fill_byte = is_signed & dataout[7];
  assign fill_half = is_signed & dataout[15];

  always_comb begin
    rdata = dataout;
    case (size)
      SIZE_BYTE: rdata = {{24{fill_byte}}, dataout[7:0]};
      SIZE_HALF: rdata = {{16{fill_half}}, dataout[15:0]};
      default:   rdata = dataout;
    endcase
  end

endmodule

// File: rtl/data_mem_access_unit.sv
// Sequences one load/store per handshake through the data RAM's setup/enable/hold protocol.
// Optional MISALIGN_TRAP_EN: misaligned or reserved-size requests fault without touching the RAM.
module data_mem_access_unit
  import data_mem_pkg::*;
#(
  parameter int PULSE_CYCLES = DEFAULT_PULSE_CYCLES,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              mem_enable,
  output logic              mem_readwrite,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_datain,
  output logic [1:0]        mem_size,
  input  logic [31:0]       mem_dataout
);

  localparam int CNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               signed_reg;
  logic               mem_enable_reg;
  logic               mem_readwrite_reg;
  logic [ADDR_W-1:0]  mem_address_reg;
  logic [31:0]        mem_datain_reg;
  logic [1:0]         mem_size_reg;
  logic               resp_valid_reg;
  logic [31:0]        resp_rdata_reg;
  logic               resp_fault_reg;

  logic               misaligned;
  logic [1:0]         eff_size;
  logic [31:0]        load_data;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = (req_size == SIZE_HALF && req_addr[0]) ||
                      (req_size == SIZE_WORD && req_addr[1:0] != 2'b00) ||
                      (req_size == SIZE_RSVD);
`else
  assign misaligned = 1'b0;
`endif

  // Reserved size is only reachable here without the trap; it behaves as a word access.
  assign eff_size = (req_size == SIZE_RSVD) ? SIZE_WORD : req_size;

  mem_load_extend u_load_extend (
    .size      (mem_size_reg),
    .is_signed (signed_reg),
    .dataout   (mem_dataout),
    .rdata     (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      cnt_reg           <= '0;
      signed_reg        <= 1'b0;
      mem_enable_reg    <= 1'b0;
      mem_readwrite_reg <= 1'b0;
      mem_address_reg   <= '0;
      mem_datain_reg    <= '0;
      mem_size_reg      <= '0;
      resp_valid_reg    <= 1'b0;
      resp_rdata_reg    <= '0;
      resp_fault_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            if (misaligned) begin
              state_reg      <= ST_RESP;
              resp_valid_reg <= 1'b1;
              resp_fault_reg <= 1'b1;
              resp_rdata_reg <= '0;
            end else begin
              state_reg         <= ST_SETUP;
              mem_address_reg   <= req_addr;
              mem_size_reg      <= eff_size;
              mem_readwrite_reg <= req_write;
              mem_datain_reg    <= format_store(eff_size, req_wdata);
              signed_reg        <= req_signed;
            end
          end
        end
        ST_SETUP: begin
          state_reg      <= ST_STROBE;
          mem_enable_reg <= 1'b1;
          cnt_reg        <= CNT_W'(PULSE_CYCLES - 1);
        end
        ST_STROBE: begin
          if (cnt_reg == '0) begin
            state_reg      <= ST_HOLD;
            mem_enable_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_HOLD: begin
          // Read data is sampled on the edge that leaves HOLD, after the RAM has settled.
          state_reg      <= ST_RESP;
          resp_valid_reg <= 1'b1;
          resp_rdata_reg <= mem_readwrite_reg ? 32'b0 : load_data;
        end
        ST_RESP: begin
          state_reg      <= ST_IDLE;
          resp_valid_reg <= 1'b0;
          resp_rdata_reg <= '0;
          resp_fault_reg <= 1'b0;
        end
        default: begin
          state_reg      <= ST_IDLE;
          mem_enable_reg <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = (state_reg == ST_IDLE) && !reset;
  assign resp_valid    = resp_valid_reg;
  assign resp_rdata    = resp_rdata_reg;
  assign resp_fault    = resp_fault_reg;
  assign mem_enable    = mem_enable_reg;
  assign mem_readwrite = mem_readwrite_reg;
  assign mem_address   = mem_address_reg;
  assign mem_datain    = mem_datain_reg;
  assign mem_size      = mem_size_reg;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed bench for data_mem_access_unit with a big-endian byte RAM model and a response scoreboard.
module tb_data_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_enable;
  logic        mem_readwrite;
  logic [31:0] mem_address;
  logic [31:0] mem_datain;
  logic [1:0]  mem_size;
  logic [31:0] mem_dataout;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_rdata_q[$];
  logic        exp_fault_q[$];
  logic [7:0]  ram[0:63];

  data_mem_access_unit dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_size      (req_size),
    .req_signed    (req_signed),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_fault    (resp_fault),
    .mem_enable    (mem_enable),
    .mem_readwrite (mem_readwrite),
    .mem_address   (mem_address),
    .mem_datain    (mem_datain),
    .mem_size      (mem_size),
    .mem_dataout   (mem_dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: big-endian byte order, junk in the unused upper lanes of narrow reads.
  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_readwrite) begin
        case (mem_size)
          2'b00: ram[mem_address[5:0]] <= mem_datain[7:0];
          2'b01: begin
            ram[mem_address[5:0]]        <= mem_datain[15:8];
            ram[mem_address[5:0] + 6'd1] <= mem_datain[7:0];
          end
          default: begin
            ram[mem_address[5:0]]        <= mem_datain[31:24];
            ram[mem_address[5:0] + 6'd1] <= mem_datain[23:16];
            ram[mem_address[5:0] + 6'd2] <= mem_datain[15:8];
            ram[mem_address[5:0] + 6'd3] <= mem_datain[7:0];
          end
        endcase
      end else begin
        case (mem_size)
          2'b00:   mem_dataout <= {24'hA5A5A5, ram[mem_address[5:0]]};
          2'b01:   mem_dataout <= {16'hA5A5, ram[mem_address[5:0]], ram[mem_address[5:0] + 6'd1]};
          default: mem_dataout <= {ram[mem_address[5:0]], ram[mem_address[5:0] + 6'd1],
                                   ram[mem_address[5:0] + 6'd2], ram[mem_address[5:0] + 6'd3]};
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input string name, input logic w, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_f,
                        input logic [1:0] exp_msz, input logic [31:0] exp_din);
    int          g;
    int          lat;
    int          en;
    logic        stable;
    logic [31:0] rd_exp;
    logic        f_exp;
    exp_rdata_q.push_back(exp_rd);
    exp_fault_q.push_back(exp_f);
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    check({name, " accept"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    en = 0;
    stable = 1'b1;
    while (!resp_valid && lat < 20) begin
      if (mem_enable) en++;
      if (mem_size !== exp_msz || mem_address !== addr || mem_readwrite !== w ||
          (w && mem_datain !== exp_din)) stable = 1'b0;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    rd_exp = exp_rdata_q.pop_front();
    f_exp  = exp_fault_q.pop_front();
    check({name, " resp_valid"}, 32'(resp_valid), 32'd1);
    check({name, " latency"}, 32'(lat), f_exp ? 32'd0 : 32'd3);
    check({name, " enable_cycles"}, 32'(en), f_exp ? 32'd0 : 32'd1);
    check({name, " mem_stable"}, 32'(stable), 32'd1);
    check({name, " rdata"}, resp_rdata, rd_exp);
    check({name, " fault"}, 32'(resp_fault), 32'(f_exp));
    $display("txn %s: write=%0d size=%0d addr=%h rdata=%h fault=%0d latency=%0d",
             name, w, sz, addr, resp_rdata, resp_fault, lat);
    @(posedge clk);
    @(negedge clk);
    check({name, " resp_pulse"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    logic saw_resp;
    for (int i = 0; i < 64; i++) ram[i] = 8'h00;
    ram[0] = 8'h80; ram[1] = 8'h12; ram[2] = 8'h34; ram[3] = 8'h56;
    mem_dataout = 32'h0;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset mem_enable", 32'(mem_enable), 32'd0);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset mem_address", mem_address, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("idle req_ready", 32'(req_ready), 32'd1);

    access("ld_b_s0",  1'b0, 2'b00, 1'b1, 32'd0, 32'h0, 32'hFFFFFF80, 1'b0, 2'b00, 32'h0);
    access("ld_b_u0",  1'b0, 2'b00, 1'b0, 32'd0, 32'h0, 32'h00000080, 1'b0, 2'b00, 32'h0);
    access("ld_h_u2",  1'b0, 2'b01, 1'b0, 32'd2, 32'h0, 32'h00003456, 1'b0, 2'b01, 32'h0);
    access("ld_h_s0",  1'b0, 2'b01, 1'b1, 32'd0, 32'h0, 32'hFFFF8012, 1'b0, 2'b01, 32'h0);
    access("st_w8",    1'b1, 2'b10, 1'b0, 32'd8, 32'hE35D8AC5, 32'h0, 1'b0, 2'b10, 32'hE35D8AC5);
    access("ld_w8",    1'b0, 2'b10, 1'b1, 32'd8, 32'h0, 32'hE35D8AC5, 1'b0, 2'b10, 32'h0);
    access("st_b0",    1'b1, 2'b00, 1'b0, 32'd0, 32'hFFFFFFB5, 32'h0, 1'b0, 2'b00, 32'h000000B5);
    access("ld_b_u0b", 1'b0, 2'b00, 1'b0, 32'd0, 32'h0, 32'h000000B5, 1'b0, 2'b00, 32'h0);
    access("ld_b_s0b", 1'b0, 2'b00, 1'b1, 32'd0, 32'h0, 32'hFFFFFFB5, 1'b0, 2'b00, 32'h0);
`ifdef MISALIGN_TRAP_EN
    access("ld_w6",    1'b0, 2'b10, 1'b0, 32'd6, 32'h0, 32'h0, 1'b1, 2'b10, 32'h0);
    access("ld_rsvd8", 1'b0, 2'b11, 1'b0, 32'd8, 32'h0, 32'h0, 1'b1, 2'b10, 32'h0);
`else
    access("ld_w6",    1'b0, 2'b10, 1'b0, 32'd6, 32'h0, 32'h0000E35D, 1'b0, 2'b10, 32'h0);
    access("ld_rsvd8", 1'b0, 2'b11, 1'b0, 32'd8, 32'h0, 32'hE35D8AC5, 1'b0, 2'b10, 32'h0);
`endif

    // Abort a load with reset while the enable pulse is active.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'd8; req_wdata = 32'h0;
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort strobe enable", 32'(mem_enable), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort mem_enable", 32'(mem_enable), 32'd0);
    check("abort req_ready", 32'(req_ready), 32'd0);
    check("abort mem_address", mem_address, 32'h0);
    check("abort mem_size", 32'(mem_size), 32'd0);
    check("abort resp_rdata", resp_rdata, 32'h0);
    reset = 1'b0;
    saw_resp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) saw_resp = 1'b1;
      @(negedge clk);
    end
    check("abort no_resp", 32'(saw_resp), 32'd0);
    check("abort req_ready_after", 32'(req_ready), 32'd1);
    $display("txn abort: reset during strobe, saw_resp=%0d", saw_resp);

    access("ld_h_s0c", 1'b0, 2'b01, 1'b1, 32'd0, 32'h0, 32'hFFFFB512, 1'b0, 2'b01, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
